// File: rtl/bft_client_tx.sv
// BFT client packet transmitter: buffers payload words in a small FIFO and emits
// {dest, payload} flits on the write-stream link toward a T-switch leaf port.
module bft_client_tx #(
    parameter int N     = 4,
    parameter int A_W   = $clog2(N) + 1,
    parameter int D_W   = 32,
    parameter int LEN_W = 8,
    parameter int FD    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ce,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [A_W-1:0]     cmd_dest,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic [D_W-1:0]     s_data,
    input  logic               s_valid,
    output logic               s_ready,
    output logic [A_W+D_W-1:0] m_axis_wdata,
    output logic               m_axis_wvalid,
    input  logic               m_axis_wready,
    output logic               m_axis_wlast,
    output logic               done,
    output logic               err,
    output logic [15:0]        pkt_count
);

    localparam int PW = $clog2(FD);
    localparam int CW = PW + 1;

    typedef enum logic {IDLE, SEND} state_t;

    state_t             state;
    state_t             state_next;

    logic [D_W-1:0]     fifo_mem [FD];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [CW-1:0]      count;
    logic               fifo_nonempty;
    logic               push;
    logic               pop;

    logic               cmd_fire;
    logic               cmd_illegal;
    logic               hs_last;
    logic [A_W-1:0]     dest_q;
    logic [LEN_W-1:0]   remaining;

    assign fifo_nonempty = (count != '0);
    assign s_ready       = ~rst & ce & (count < CW'(FD));
    assign push          = s_valid & s_ready;

    assign cmd_fire      = cmd_valid & cmd_ready;
    assign cmd_illegal   = (cmd_len == '0) | ({1'b0, cmd_dest} >= (A_W+1)'(N));
    assign hs_last       = m_axis_wvalid & m_axis_wready & m_axis_wlast;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else if (ce) begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (cmd_fire && !cmd_illegal) state_next = SEND;
            SEND: if (pop && remaining == LEN_W'(1)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A pop may refill the output register in the same cycle its flit handshakes.
    always_comb begin
        cmd_ready = 1'b0;
        pop       = 1'b0;
        case (state)
            IDLE: cmd_ready = ~rst & ce;
            SEND: pop = ce & fifo_nonempty & (~m_axis_wvalid | m_axis_wready);
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dest_q        <= '0;
            remaining     <= '0;
            m_axis_wvalid <= 1'b0;
            m_axis_wdata  <= '0;
            m_axis_wlast  <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            pkt_count     <= '0;
        end else if (ce) begin
            done <= hs_last;
            err  <= cmd_fire & cmd_illegal;
            if (hs_last) begin
                pkt_count <= pkt_count + 16'd1;
            end

            if (cmd_fire && !cmd_illegal) begin
                dest_q    <= cmd_dest;
                remaining <= cmd_len;
            end else if (pop) begin
                remaining <= remaining - LEN_W'(1);
            end

            if (pop) begin
                m_axis_wvalid <= 1'b1;
                m_axis_wdata  <= {dest_q, fifo_mem[rd_ptr]};
                m_axis_wlast  <= (remaining == LEN_W'(1));
            end else if (m_axis_wvalid && m_axis_wready) begin
                m_axis_wvalid <= 1'b0;
                m_axis_wlast  <= 1'b0;
            end
        end
    end

endmodule
